// File: rtl/logic_op_stream.sv
// Streaming bitwise AND/OR stage with a small result FIFO and transfer counter.
// Define LOGIC_OP_XOR_EN to add an out_xor result lane.
module logic_op_stream #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_and,
    output logic [WIDTH-1:0] out_or,
`ifdef LOGIC_OP_XOR_EN
    output logic [WIDTH-1:0] out_xor,
`endif
    output logic [CNT_W-1:0] txn_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_EMPTY = '0;
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CNT_W-1:0] TXN_ONE = CNT_W'(1);

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic             push, pop;

    logic [WIDTH-1:0] and_q [DEPTH];
    logic [WIDTH-1:0] or_q  [DEPTH];
`ifdef LOGIC_OP_XOR_EN
    logic [WIDTH-1:0] xor_q [DEPTH];
`endif

    // Handshake flags depend only on registered occupancy.
    assign out_valid = (cnt_q != CNT_EMPTY);
    assign in_ready  = (cnt_q != CNT_FULL);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        txn_d = txn_q;
        if (push) begin
            wr_d = wr_q + PTR_ONE;
        end
        if (pop) begin
            rd_d  = rd_q + PTR_ONE;
            txn_d = txn_q + TXN_ONE;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            txn_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            txn_q <= txn_d;
        end
    end

    // Storage needs no reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            and_q[wr_q] <= in_a & in_b;
            or_q[wr_q]  <= in_a | in_b;
`ifdef LOGIC_OP_XOR_EN
            xor_q[wr_q] <= in_a ^ in_b;
`endif
        end
    end

    assign out_and   = out_valid ? and_q[rd_q] : '0;
    assign out_or    = out_valid ? or_q[rd_q]  : '0;
`ifdef LOGIC_OP_XOR_EN
    assign out_xor   = out_valid ? xor_q[rd_q] : '0;
`endif
    assign txn_count = txn_q;

endmodule

// File: tb/tb_logic_op_stream.sv
// Randomized and directed bench for logic_op_stream against a queue model.
// Checks every cycle plus literal expectations from hand-worked cases.
module tb_logic_op_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_and;
    logic [3:0] out_or;
    logic [7:0] txn_count;
`ifdef LOGIC_OP_XOR_EN
    logic [3:0] out_xor;
`endif

    logic_op_stream #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_and   (out_and),
        .out_or    (out_or),
`ifdef LOGIC_OP_XOR_EN
        .out_xor   (out_xor),
`endif
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
    } pair_t;

    pair_t q[$];
    int    model_txn;
    int    vectors;
    int    errors;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all DUT outputs against the queue model.
    task automatic check_model();
        logic [3:0] ea, eo, ex;
        ea = 4'd0;
        eo = 4'd0;
        ex = 4'd0;
        if (q.size() > 0) begin
            ea = q[0].a & q[0].b;
            eo = q[0].a | q[0].b;
            ex = q[0].a ^ q[0].b;
        end
        chk("model out_valid", int'(out_valid), int'(q.size() > 0));
        chk("model in_ready", int'(in_ready), int'(q.size() < 2));
        chk("model out_and", int'(out_and), int'(ea));
        chk("model out_or", int'(out_or), int'(eo));
        chk("model txn_count", int'(txn_count), model_txn % 256);
`ifdef LOGIC_OP_XOR_EN
        chk("model out_xor", int'(out_xor), int'(ex));
`else
        if (ex != ex) errors++;
`endif
    endtask

    // Apply one cycle of inputs, advance the model, then check after negedge.
    task automatic cycle(input logic r, input logic iv, input logic [3:0] a,
                         input logic [3:0] b, input logic ordy);
        bit do_push, do_pop;
        pair_t p;
        rst       = r;
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        do_push = iv && (q.size() < 2);
        do_pop  = ordy && (q.size() > 0);
        @(posedge clk);
        if (r) begin
            q.delete();
            model_txn = 0;
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                model_txn++;
            end
            if (do_push) begin
                p.a = a;
                p.b = b;
                q.push_back(p);
            end
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        model_txn = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        out_ready = 1'b0;

        // Reset state
        cycle(1, 0, 4'd0, 4'd0, 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_and", int'(out_and), 0);
        chk("rst out_or", int'(out_or), 0);
        chk("rst txn", int'(txn_count), 0);

        // Single push, one-cycle latency
        cycle(0, 1, 4'b0110, 4'b1010, 1);
        chk("t1 out_valid", int'(out_valid), 1);
        chk("t1 out_and", int'(out_and), 4'b0010);
        chk("t1 out_or", int'(out_or), 4'b1110);
`ifdef LOGIC_OP_XOR_EN
        chk("t1 out_xor", int'(out_xor), 4'b1100);
`endif
        cycle(0, 0, 4'd0, 4'd0, 1);
        chk("t1 drained", int'(out_valid), 0);
        chk("t1 txn", int'(txn_count), 1);

        // Fill, backpressure, rejected third pair
        cycle(0, 1, 4'b1111, 4'b0000, 0);
        cycle(0, 1, 4'b0011, 4'b0101, 0);
        chk("t2 full in_ready", int'(in_ready), 0);
        cycle(0, 1, 4'b1001, 4'b1001, 0);
        chk("t2 hold and", int'(out_and), 4'b0000);
        chk("t2 hold or", int'(out_or), 4'b1111);
        cycle(0, 0, 4'd0, 4'd0, 1);
        chk("t2 second and", int'(out_and), 4'b0001);
        chk("t2 second or", int'(out_or), 4'b0111);
        cycle(0, 0, 4'd0, 4'd0, 1);
        chk("t2 empty", int'(out_valid), 0);
        chk("t2 txn", int'(txn_count), 3);

        // Streaming: one result per cycle
        cycle(0, 1, 4'($urandom), 4'($urandom), 1);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 4'($urandom), 4'($urandom), 1);
            chk("t3 stream valid", int'(out_valid), 1);
            chk("t3 stream ready", int'(in_ready), 1);
        end
        cycle(0, 0, 4'd0, 4'd0, 1);

        // Reset while full discards entries
        cycle(0, 1, 4'b1100, 4'b1010, 0);
        cycle(0, 1, 4'b0101, 4'b0110, 0);
        cycle(1, 1, 4'b1111, 4'b1111, 1);
        chk("t4 valid", int'(out_valid), 0);
        chk("t4 ready", int'(in_ready), 1);
        chk("t4 and", int'(out_and), 0);
        chk("t4 txn", int'(txn_count), 0);
        cycle(0, 0, 4'd0, 4'd0, 1);
        chk("t4 no stale", int'(out_valid), 0);

        // Counter wrap after 256 transfers
        cycle(0, 1, 4'($urandom), 4'($urandom), 1);
        for (int k = 1; k <= 256; k++) begin
            cycle(0, k < 256, 4'($urandom), 4'($urandom), 1);
            if (k == 255) chk("t5 txn 255", int'(txn_count), 255);
            if (k == 256) chk("t5 txn wrap", int'(txn_count), 0);
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
                  4'($urandom), 4'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/logic_op_stream.md
Name: logic_op_stream

Overview:
- Streaming bitwise AND/OR stage.
- Accepts operand pairs from an upstream producer through a valid/ready handshake.
- Computes a&b and a|b, and buffers result pairs in a small FIFO.
- Presents the buffered results to a downstream consumer (display/checker stage) through a second valid/ready handshake, and counts completed result transfers.

Parameters:
- WIDTH, 4, bit width of each operand and each result.
- DEPTH, 2, result FIFO depth in entries; power of two, minimum 2.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- out_valid  output  1  result pair available.
- out_ready  input  1  downstream accepts the result pair this cycle.
- out_and  output  WIDTH  a&b of the head entry.
- out_or  output  WIDTH  a|b of the head entry.
- txn_count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- One clock; reset is synchronous and active-high.
- rst high at a rising edge:
  - FIFO flushed: count=0, read and write pointers=0.
  - txn_count=0.
  - Outputs after that edge: out_valid=0, in_ready=1, out_and=0, out_or=0.
  - Any entries in flight when reset is asserted mid-operation are discarded. No handshake is honoured on a reset edge.
- Push: an edge with in_valid && in_ready writes {in_a&in_b, in_a|in_b} at the write pointer. The write pointer increments modulo DEPTH.
- Pop: an edge with out_valid && out_ready advances the read pointer modulo DEPTH and increments txn_count. txn_count wraps from 2^CNT_W-1 to 0.
- Occupancy states, derived from count:
  - EMPTY (count=0): out_valid=0, in_ready=1.
  - PARTIAL (0<count<DEPTH): out_valid=1, in_ready=1.
  - FULL (count=DEPTH): out_valid=1, in_ready=0.
- State transitions:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop on the same edge: count unchanged (possible only in PARTIAL).
  - EMPTY to PARTIAL on push.
  - PARTIAL to FULL on push without pop when count=DEPTH-1.
  - FULL to PARTIAL on pop.
  - PARTIAL to EMPTY on pop without push when count=1.
- in_ready and out_valid are functions of registered count only. There is no combinational path from out_ready to in_ready or from in_valid to out_valid.
- When FULL, in_ready is 0 even if out_ready is 1 in the same cycle. A freed slot is visible one cycle later.
- Latency: a pair accepted at edge N into an EMPTY FIFO gives out_valid=1 with its results during cycle N+1. There is no combinational bypass.
- While out_valid=1 and out_ready=0, out_and and out_or hold stable.
- When EMPTY, out_and=0 and out_or=0 regardless of RAM contents.
- Ordering is strictly first-in first-out. No entry is dropped or duplicated.
- in_valid while in_ready=0 has no effect. Upstream must hold its data; the block does not latch it.
- Widths: results are exactly WIDTH bits, bitwise, with no carry or extension.

Optional Feature:
- Macro: LOGIC_OP_XOR_EN.
- When defined:
  - An extra output port out_xor (WIDTH) is added.
  - Each FIFO entry also stores in_a^in_b.
  - out_xor follows the same hold, zero-when-empty and reset rules as out_and.
- When undefined:
  - The port is absent and entries store only the AND and OR results.
  - Otherwise behaviour is identical.

Test Plan:
- Reset, then a single push of a=0110, b=1010 with out_ready=1 → next cycle out_valid=1, out_and=0010, out_or=1110; one cycle later out_valid=0 and txn_count=1.
- out_ready=0, push 1111/0000, then 0011/0101, then attempt 1001/1001 → in_ready=0 after the second push; the third pair is not accepted. Then out_ready=1 → outputs 0000/1111 then 0001/0111; the third pair is never output.
- Continuous in_valid=1 and out_ready=1 with DEPTH=2 → one result per cycle after a 1-cycle latency; count stays at 1; in order.
- Assert rst while count=2 → next cycle out_valid=0, in_ready=1, out_and=0, txn_count=0; stale entries never appear.
- Perform 256 output transfers with CNT_W=8 → txn_count reads 255 after 255 transfers and 0 after 256.
- With LOGIC_OP_XOR_EN defined, push a=0110, b=1010 → out_xor=1100 alongside out_and=0010 and out_or=1110.
